muldiv_unit: RTL and testbench

Parametrised iterative RV32M/RV64M multiply/divide unit that sits in the execute stage alongside the ALU.
- Takes already-forwarded operands, runs the selected M-extension operation over several cycles, and raises a stall to the hazard unit until the result is ready.
- Generalises the single-cycle execute datapath to a configurable width XLEN and a configurable number of bits processed per cycle, with flush support.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/muldiv_iter_step.sv | 53 +++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV M-extension definitions for the execute-stage multiply/divide unit.
// Provides the funct3 encodings, the iterative unit's state type, the default
// datapath width and small decode helpers for operand signedness.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

  // MUL keeps only the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic f3_signed_a(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// Combinational radix-2^BITS_PER_CYCLE step of the iterative multiply/divide.
// Ports:
//   i_div   : 0 = shift-add multiply, 1 = restoring divide
//   i_acc   : multiply {partial hi, multiplier lo}; divide {R, Q}
//   i_opnd  : multiplicand (multiply) or divisor (divide), magnitudes only
//   o_acc   : accumulator after BITS_PER_CYCLE retired bits
module muldiv_iter_step
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] w_acc;
  logic [2*XLEN-1:0] w_shift;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;

  always_comb begin
    w_acc   = i_acc;
    w_shift = '0;
    w_sum   = '0;
    w_trial = '0;
    w_diff  = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i_div) begin
        // R < divisor always holds, so the shifted remainder needs one extra
        // bit only for the trial subtract; a negative diff shows in the MSB.
        w_trial = {w_acc[2*XLEN-1:XLEN], w_acc[XLEN-1]};
        w_diff  = w_trial - {1'b0, i_opnd};
        w_shift = {w_acc[2*XLEN-2:0], 1'b0};
        if (!w_diff[XLEN]) begin
          w_acc = {w_diff[XLEN-1:0], w_shift[XLEN-1:1], 1'b1};
        end else begin
          w_acc = w_shift;
        end
      end else begin
        // Multiplier is consumed LSB-first from the low half while the
        // product fills in from the top; carry lands in bit 2*XLEN-1.
        w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} + (w_acc[0] ? {1'b0, i_opnd} : '0);
        w_acc = {w_sum, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Latches forwarded operands, iterates XLEN/BITS_PER_CYCLE cycles, and stalls
// the pipeline until the one-cycle result pulse. Divide-by-zero and signed
// overflow finish in one cycle.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   valid_i                 : M-op present in execute (held while stall_o)
//   funct3_i, op_a_i, op_b_i, rd_i : operation, operands, destination
//   flush_i                 : kill in-flight op
//   stall_o                 : freeze front-end pipeline registers
//   busy_o                  : not idle
//   result_valid_o          : one-cycle pulse with result_o / rd_o
//   result_o, rd_o          : result and its destination (held between pulses)
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int unsigned     N        = XLEN / BITS_PER_CYCLE;
  localparam int unsigned     CW       = $clog2(N) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [2:0]        r_f3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [4:0]        r_rd;
  logic [4:0]        r_rd_out;
  logic [XLEN-1:0]   r_result;
  logic              r_result_valid;

  logic              w_sgn_a;
  logic              w_sgn_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_fast_res;
  logic [2*XLEN-1:0] w_step_acc;
  logic [2*XLEN-1:0] w_prod_neg;
  logic [XLEN-1:0]   w_lo_neg;
  logic [XLEN-1:0]   w_hi_neg;
  logic [XLEN-1:0]   w_final;

  assign w_sgn_a    = f3_signed_a(funct3_i) & op_a_i[XLEN-1];
  assign w_sgn_b    = f3_signed_b(funct3_i) & op_b_i[XLEN-1];
  assign w_abs_a    = w_sgn_a ? -op_a_i : op_a_i;
  assign w_abs_b    = w_sgn_b ? -op_b_i : op_b_i;
  assign w_div_zero = funct3_i[2] & (op_b_i == '0);
  assign w_ovf      = ((funct3_i == F3_DIV) | (funct3_i == F3_REM)) &
                      (op_a_i == MOST_NEG) & (op_b_i == '1);

  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = funct3_i[1] ? op_a_i : '1;
    end else begin
      w_fast_res = funct3_i[1] ? '0 : op_a_i;
    end
  end

  muldiv_iter_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .i_div (r_f3[2]),
    .i_acc (r_acc),
    .i_opnd(r_opnd),
    .o_acc (w_step_acc)
  );

  // Result is formed from the last step's output so it can be registered on
  // the CALC->DONE edge. High-half products negate the full 2*XLEN value.
  assign w_prod_neg = -w_step_acc;
  assign w_lo_neg   = -w_step_acc[XLEN-1:0];
  assign w_hi_neg   = -w_step_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_f3)
      F3_MUL:                       w_final = w_step_acc[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = r_neg_q ? w_prod_neg[2*XLEN-1:XLEN]
                                                      : w_step_acc[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_final = r_neg_q ? w_lo_neg : w_step_acc[XLEN-1:0];
      default:                      w_final = r_neg_r ? w_hi_neg : w_step_acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= MD_IDLE;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_opnd         <= '0;
      r_f3           <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_rd           <= '0;
      r_rd_out       <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (flush_i) begin
      r_state        <= MD_IDLE;
      r_cnt          <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (valid_i) begin
            r_f3  <= funct3_i;
            r_rd  <= rd_i;
            r_cnt <= '0;
            if (w_div_zero | w_ovf) begin
              r_result       <= w_fast_res;
              r_rd_out       <= rd_i;
              r_result_valid <= 1'b1;
              r_state        <= MD_DONE;
            end else begin
              r_neg_q <= w_sgn_a ^ w_sgn_b;
              r_neg_r <= w_sgn_a;
              if (funct3_i[2]) begin
                r_acc  <= {{XLEN{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
              end else begin
                r_acc  <= {{XLEN{1'b0}}, w_abs_b};
                r_opnd <= w_abs_a;
              end
              r_state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_result       <= w_final;
            r_rd_out       <= r_rd;
            r_result_valid <= 1'b1;
            r_state        <= MD_DONE;
          end
        end
        MD_DONE: begin
          r_result_valid <= 1'b0;
          r_state        <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign stall_o        = !flush_i & (((r_state == MD_IDLE) & valid_i) | (r_state == MD_CALC));
  assign busy_o         = (r_state != MD_IDLE);
  assign result_valid_o = r_result_valid & !flush_i;
  assign result_o       = r_result;
  assign rd_o           = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic [2:0]  f3;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  rd;

  logic        stall32, busy32, rv32;
  logic [31:0] res32;
  logic [4:0]  rdo32;
  logic        stall64, busy64, rv64;
  logic [63:0] res64;
  logic [4:0]  rdo64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut32 (
    .clk(clk), .rst(rst), .valid_i(valid), .funct3_i(f3),
    .op_a_i(a[31:0]), .op_b_i(b[31:0]), .rd_i(rd), .flush_i(flush),
    .stall_o(stall32), .busy_o(busy32), .result_valid_o(rv32),
    .result_o(res32), .rd_o(rdo32)
  );

  muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut64 (
    .clk(clk), .rst(rst), .valid_i(valid), .funct3_i(f3),
    .op_a_i(a), .op_b_i(b), .rd_i(rd), .flush_i(flush),
    .stall_o(stall64), .busy_o(busy64), .result_valid_o(rv64),
    .result_o(res64), .rd_o(rdo64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic obs_stall(input bit w); return w ? stall64 : stall32; endfunction
  function automatic logic obs_busy(input bit w);  return w ? busy64 : busy32;   endfunction
  function automatic logic obs_rv(input bit w);    return w ? rv64 : rv32;       endfunction
  function automatic logic [63:0] obs_res(input bit w); return w ? res64 : {32'd0, res32}; endfunction
  function automatic logic [4:0] obs_rd(input bit w);   return w ? rdo64 : rdo32;         endfunction

  // Reference for the 64-bit instance: native wide arithmetic.
  function automatic logic [63:0] model64(input logic [2:0] fn, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xs, ys, xu, yu, p;
    logic [63:0]  r;
    logic         ovf;
    xs  = {{64{x[63]}}, x};
    ys  = {{64{y[63]}}, y};
    xu  = {64'd0, x};
    yu  = {64'd0, y};
    ovf = (x == 64'h8000_0000_0000_0000) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
    p   = '0;
    r   = '0;
    case (fn)
      F3_MUL:    begin p = xu * yu; r = p[63:0];   end
      F3_MULH:   begin p = xs * ys; r = p[127:64]; end
      F3_MULHSU: begin p = xs * yu; r = p[127:64]; end
      F3_MULHU:  begin p = xu * yu; r = p[127:64]; end
      F3_DIV:    r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? x : 64'($signed(x) / $signed(y));
      F3_DIVU:   r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
      F3_REM:    r = (y == 0) ? x : ovf ? 64'd0 : 64'($signed(x) % $signed(y));
      default:   r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Called just after driving an op at cycle 0; returns at the negedge of the
  // cycle following the result pulse, with valid dropped.
  task automatic wait_result(input string tag, input bit w, input logic [63:0] exp,
                             input int lat, input logic [4:0] exp_rd);
    int cyc = 0;
    bit got = 1'b0;
    int stall_bad = 0;
    while (!got && cyc <= 200) begin
      @(negedge clk);
      if (obs_rv(w)) begin
        got = 1'b1;
      end else begin
        if (!obs_stall(w)) stall_bad++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, ".seen"},       64'(got), 64'd1);
    check({tag, ".lat"},        64'(cyc), 64'(lat));
    check({tag, ".res"},        obs_res(w), exp);
    check({tag, ".rd"},         64'(obs_rd(w)), 64'(exp_rd));
    check({tag, ".stall"},      64'(stall_bad), 64'd0);
    check({tag, ".stall_done"}, 64'(obs_stall(w)), 64'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check({tag, ".pulse"}, 64'(obs_rv(w)), 64'd0);
    check({tag, ".idle"},  64'(obs_busy(w)), 64'd0);
    check({tag, ".hold"},  obs_res(w), exp);
  endtask

  task automatic run_op(input string tag, input bit w, input logic [2:0] fn,
                        input logic [63:0] opa, input logic [63:0] opb,
                        input logic [4:0] r, input logic [63:0] exp, input int lat);
    @(posedge clk); #1;
    valid = 1'b1; f3 = fn; a = opa; b = opb; rd = r;
    wait_result(tag, w, exp, lat, r);
  endtask

  initial begin
    bit          seen;
    logic [63:0] ra, rb;
    int          lat;

    rst = 1'b1; valid = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy32",  64'(busy32), 64'd0);
    check("reset.stall32", 64'(stall32), 64'd0);
    check("reset.rv32",    64'(rv32), 64'd0);
    check("reset.res32",   {32'd0, res32}, 64'd0);
    check("reset.rd32",    64'(rdo32), 64'd0);
    check("reset.busy64",  64'(busy64), 64'd0);
    check("reset.res64",   res64, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 32-bit, 1 bit/cycle: iterative ops finish at cycle 33, fast paths at 1.
    run_op("mul",      0, F3_MUL,    64'h7,         64'hFFFF_FFFD, 5'd7,  64'hFFFF_FFEB, 33);
    run_op("mulhu",    0, F3_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd8,  64'hFFFF_FFFE, 33);
    run_op("mulh",     0, F3_MULH,   64'h8000_0000, 64'h8000_0000, 5'd9,  64'h4000_0000, 33);
    run_op("mulh_neg", 0, F3_MULH,   64'hFFFF_FFFD, 64'h5,         5'd10, 64'hFFFF_FFFF, 33);
    run_op("mulhsu",   0, F3_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd11, 64'hFFFF_FFFF, 33);
    run_op("div",      0, F3_DIV,    64'hFFFF_FFF9, 64'h2,         5'd12, 64'hFFFF_FFFD, 33);
    run_op("rem",      0, F3_REM,    64'hFFFF_FFF9, 64'h2,         5'd13, 64'hFFFF_FFFF, 33);
    run_op("div_nb",   0, F3_DIV,    64'h7,         64'hFFFF_FFFE, 5'd14, 64'hFFFF_FFFD, 33);
    run_op("rem_nb",   0, F3_REM,    64'h7,         64'hFFFF_FFFE, 5'd15, 64'h1,         33);
    run_op("divu",     0, F3_DIVU,   64'd100,       64'd7,         5'd16, 64'd14,        33);
    run_op("remu",     0, F3_REMU,   64'd100,       64'd7,         5'd17, 64'd2,         33);
    run_op("divu_z",   0, F3_DIVU,   64'd5,         64'd0,         5'd18, 64'hFFFF_FFFF, 1);
    run_op("rem_z",    0, F3_REM,    64'd5,         64'd0,         5'd19, 64'd5,         1);
    run_op("div_ovf",  0, F3_DIV,    64'h8000_0000, 64'hFFFF_FFFF, 5'd20, 64'h8000_0000, 1);
    run_op("rem_ovf",  0, F3_REM,    64'h8000_0000, 64'hFFFF_FFFF, 5'd21, 64'd0,         1);

    // Flush at cycle 10 of a MUL, then DIVU 9/3 issued at cycle 11.
    @(posedge clk); #1;
    valid = 1'b1; f3 = F3_MUL; a = 64'd5; b = 64'd6; rd = 5'd22;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rv32) seen = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush.stall", 64'(stall32), 64'd0);
    if (rv32) seen = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; f3 = F3_DIVU; a = 64'd9; b = 64'd3; rd = 5'd23;
    check("flush.busy", 64'(busy32), 64'd0);
    check("flush.no_result", 64'(seen), 64'd0);
    wait_result("divu_after_flush", 0, 64'd3, 33, 5'd23);

    // Flush landing in DONE of a fast-path op hides the pulse.
    @(posedge clk); #1;
    valid = 1'b1; f3 = F3_DIVU; a = 64'd5; b = 64'd0; rd = 5'd3;
    @(negedge clk);
    check("flushdone.stall0", 64'(stall32), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flushdone.rv",   64'(rv32), 64'd0);
    check("flushdone.busy", 64'(busy32), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flushdone.idle", 64'(busy32), 64'd0);
    check("flushdone.rv2",  64'(rv32), 64'd0);

    // Reset at cycle 5 of a DIV clears everything and aborts the result.
    @(posedge clk); #1;
    valid = 1'b1; f3 = F3_DIV; a = 64'd100; b = 64'd7; rd = 5'd5;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy",  64'(busy32), 64'd0);
    check("rst.stall", 64'(stall32), 64'd0);
    check("rst.rv",    64'(rv32), 64'd0);
    check("rst.res",   {32'd0, res32}, 64'd0);
    check("rst.rd",    64'(rdo32), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rv32) seen = 1'b1;
    end
    check("rst.no_result", 64'(seen), 64'd0);

    // 64-bit, 4 bits/cycle: 16 iterations, result at cycle 17.
    run_op("mul64", 1, F3_MUL, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 17);
    for (int unsigned fn = 0; fn < 8; fn++) begin
      for (int unsigned k = 0; k < 24; k++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (k % 4 == 3) rb = rb >> 40;
        if (k == 1) rb = 64'd0;
        if (k == 2) begin
          ra = 64'h8000_0000_0000_0000;
          rb = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        lat = 17;
        if (fn >= 4 && (rb == 0 || ((fn == 4 || fn == 6) &&
            ra == 64'h8000_0000_0000_0000 && rb == 64'hFFFF_FFFF_FFFF_FFFF)))
          lat = 1;
        run_op($sformatf("rnd64_f%0d_%0d", fn, k), 1, 3'(fn), ra, rb, 5'(k),
               model64(3'(fn), ra, rb), lat);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
